conv_loop_controller: RTL

CONV_LOOP_CONTROLLER -- requirements
Module: conv_loop_controller

---
 rtl/conv_loop_controller.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/conv_loop_controller.sv
`timescale 1ns/1ps
// conv_loop_controller: walks the six convolution loops (y, x, ch_out, ch_in, ky, kx) for one layer per start.
// Latency: first step offered the cycle after start; output_valid follows its last MAC handshake by one cycle.
// Backpressure: step_valid/step_ready handshake; all indices hold while step_ready is low.
module conv_loop_controller #(
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int INPUT_NB_CHANNELS  = 2,
   parameter int OUTPUT_NB_CHANNELS = 16,
   parameter int KERNEL_SIZE        = 3,
   parameter int MAX_STRIDE         = 4,
   localparam int SW  = $clog2(MAX_STRIDE + 1),
   localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1,
   localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1,
   localparam int CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1,
   localparam int COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1,
   localparam int KW  = (KERNEL_SIZE        > 1) ? $clog2(KERNEL_SIZE)        : 1
) (
   input  logic           clk,
   input  logic           arst_n_in,
   input  logic           start,
   input  logic [SW-1:0]  conv_stride,
   output logic           running,
   output logic           step_valid,
   input  logic           step_ready,
   output logic [XW-1:0]  x,
   output logic [YW-1:0]  y,
   output logic [CIW-1:0] ch_in,
   output logic [COW-1:0] ch_out,
   output logic [KW-1:0]  kx,
   output logic [KW-1:0]  ky,
   output logic           last_acc,
   output logic           output_valid,
   output logic [XW-1:0]  output_x,
   output logic [YW-1:0]  output_y,
   output logic [COW-1:0] output_ch,
   output logic           done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [31:0]    FMW_U  = FEATURE_MAP_WIDTH;
   localparam logic [31:0]    FMH_U  = FEATURE_MAP_HEIGHT;
   localparam logic [31:0]    MS_U   = MAX_STRIDE;
   localparam logic [KW-1:0]  K_MAX  = KW'(KERNEL_SIZE - 1);
   localparam logic [CIW-1:0] CI_MAX = CIW'(INPUT_NB_CHANNELS - 1);
   localparam logic [COW-1:0] CO_MAX = COW'(OUTPUT_NB_CHANNELS - 1);

   state_t         r_state;
   state_t         w_state_nxt;
   logic [SW-1:0]  r_stride;
   logic [XW-1:0]  r_x;
   logic [YW-1:0]  r_y;
   // ox/oy count output pixels alongside x/y so x/s and y/s never need a divider
   logic [XW-1:0]  r_ox;
   logic [YW-1:0]  r_oy;
   logic [CIW-1:0] r_ci;
   logic [COW-1:0] r_co;
   logic [KW-1:0]  r_kx;
   logic [KW-1:0]  r_ky;
   logic           r_running;
   logic           r_out_vld;
   logic [XW-1:0]  r_out_x;
   logic [YW-1:0]  r_out_y;
   logic [COW-1:0] r_out_ch;

   logic           w_accept;
   logic           w_hs;
   logic [SW-1:0]  w_stride_eff;
   logic [31:0]    w_x_sum;
   logic [31:0]    w_y_sum;
   logic           w_kx_wrap;
   logic           w_ky_wrap;
   logic           w_ci_wrap;
   logic           w_co_wrap;
   logic           w_x_wrap;
   logic           w_y_wrap;
   logic           w_ky_adv;
   logic           w_ci_adv;
   logic           w_co_adv;
   logic           w_x_adv;
   logic           w_y_adv;
   logic           w_last_acc;
   logic           w_final;

   assign w_accept = (r_state == S_IDLE) && start;
   assign w_hs     = (r_state == S_RUN) && step_ready;

   // Out-of-range strides (0 or above MAX_STRIDE) fall back to unit stride
   always_comb begin
      w_stride_eff = SW'(1);
      if ((conv_stride != '0) && (32'(conv_stride) <= MS_U)) begin
         w_stride_eff = conv_stride;
      end
   end

   // Wrap detection: spatial coordinates wrap when the next strided value leaves the map
   always_comb begin
      w_x_sum   = 32'(r_x) + 32'(r_stride);
      w_y_sum   = 32'(r_y) + 32'(r_stride);
      w_x_wrap  = (w_x_sum >= FMW_U);
      w_y_wrap  = (w_y_sum >= FMH_U);
      w_kx_wrap = (r_kx == K_MAX);
      w_ky_wrap = (r_ky == K_MAX);
      w_ci_wrap = (r_ci == CI_MAX);
      w_co_wrap = (r_co == CO_MAX);
   end

   assign w_ky_adv   = w_hs & w_kx_wrap;
   assign w_ci_adv   = w_ky_adv & w_ky_wrap;
   assign w_co_adv   = w_ci_adv & w_ci_wrap;
   assign w_x_adv    = w_co_adv & w_co_wrap;
   assign w_y_adv    = w_x_adv & w_x_wrap;
   assign w_last_acc = w_ci_wrap & w_ky_wrap & w_kx_wrap;
   assign w_final    = w_last_acc & w_co_wrap & w_x_wrap & w_y_wrap;

   // State register
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; start is only looked at in IDLE
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_hs && w_final) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Loop counters: a counter moves only when every inner counter wraps in the same handshake
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_stride <= '0;
         r_kx     <= '0;
         r_ky     <= '0;
         r_ci     <= '0;
         r_co     <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_ox     <= '0;
         r_oy     <= '0;
      end else if (w_accept) begin
         r_stride <= w_stride_eff;
         r_kx     <= '0;
         r_ky     <= '0;
         r_ci     <= '0;
         r_co     <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_ox     <= '0;
         r_oy     <= '0;
      end else begin
         if (w_hs) begin
            r_kx <= w_kx_wrap ? '0 : r_kx + 1'b1;
         end
         if (w_ky_adv) begin
            r_ky <= w_ky_wrap ? '0 : r_ky + 1'b1;
         end
         if (w_ci_adv) begin
            r_ci <= w_ci_wrap ? '0 : r_ci + 1'b1;
         end
         if (w_co_adv) begin
            r_co <= w_co_wrap ? '0 : r_co + 1'b1;
         end
         if (w_x_adv) begin
            r_x  <= w_x_wrap ? '0 : w_x_sum[XW-1:0];
            r_ox <= w_x_wrap ? '0 : r_ox + 1'b1;
         end
         if (w_y_adv) begin
            r_y  <= w_y_wrap ? '0 : w_y_sum[YW-1:0];
            r_oy <= w_y_wrap ? '0 : r_oy + 1'b1;
         end
      end
   end

   // running tracks the layer from the cycle after acceptance until the cycle after done
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_running <= 1'b0;
      end else if (w_accept) begin
         r_running <= 1'b1;
      end else if (r_state == S_DONE) begin
         r_running <= 1'b0;
      end
   end

   // Completed-pixel report, one cycle after the last MAC of that pixel is accepted
   always_ff @(posedge clk or negedge arst_n_in) begin
      if (!arst_n_in) begin
         r_out_vld <= 1'b0;
         r_out_x   <= '0;
         r_out_y   <= '0;
         r_out_ch  <= '0;
      end else begin
         r_out_vld <= w_hs & w_last_acc;
         if (w_hs && w_last_acc) begin
            r_out_x  <= r_ox;
            r_out_y  <= r_oy;
            r_out_ch <= r_co;
         end
      end
   end

   assign running      = r_running;
   assign step_valid   = (r_state == S_RUN);
   assign last_acc     = (r_state == S_RUN) && w_last_acc;
   assign done         = (r_state == S_DONE);
   assign x            = r_x;
   assign y            = r_y;
   assign ch_in        = r_ci;
   assign ch_out       = r_co;
   assign kx           = r_kx;
   assign ky           = r_ky;
   assign output_valid = r_out_vld;
   assign output_x     = r_out_x;
   assign output_y     = r_out_y;
   assign output_ch    = r_out_ch;

endmodule
